// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the data-side load/store path:
// funct3 size/sign encodings and the load/store unit state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } lsu_state_t;

  // 011, 110 and 111 have no RV32I load/store meaning.
  function automatic logic f3_legal(input logic [2:0] f3);
    return !((f3 == 3'b011) || (f3[2:1] == 2'b11));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobe/replication and load
// lane selection with sign or zero extension. Sub-size address bits are ignored.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
  assign rhalf = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_val = '0;
    case (funct3)
      F3_B:    load_val = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_val = {24'h000000, rbyte};
      F3_H:    load_val = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_val = {16'h0000, rhalf};
      F3_W:    load_val = rdata;
      default: load_val = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side memory stage: one outstanding valid/ready word access per load/store,
// stalling the core until done. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t  state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        legal;
  logic        access_mis;
  logic        in_bus;
  logic [2:0]  align_f3;
  logic [1:0]  align_lo;
  logic [3:0]  align_strb;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  assign legal  = f3_legal(funct3);
  assign in_bus = (state_q == BUS);
  assign stall  = mem_req & (state_q != DONE);

  // Live request drives store steering at issue; registered attributes drive load extraction.
  assign align_f3 = in_bus ? funct3_q  : funct3;
  assign align_lo = in_bus ? addr_lo_q : addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign access_mis = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
`else
  assign access_mis = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (align_f3),
    .addr_lo    (align_lo),
    .store_data (store_data),
    .rdata      (bus_rdata),
    .wstrb      (align_strb),
    .wdata      (align_wdata),
    .load_val   (align_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_wstrb <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      load_data <= '0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_req) begin
            if (!legal) begin
              state_q   <= DONE;
              load_data <= '0;
            end else if (access_mis) begin
              state_q <= DONE;
            end else begin
              state_q   <= BUS;
              bus_valid <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wstrb <= mem_we ? align_strb : 4'b0000;
              bus_wdata <= align_wdata;
              funct3_q  <= funct3;
              addr_lo_q <= addr[1:0];
            end
          end
        end
        BUS: begin
          if (bus_ready) begin
            state_q   <= DONE;
            bus_valid <= 1'b0;
            if (!bus_we) load_data <= align_load;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // High only in the DONE cycle that follows a trapped request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned <= 1'b0;
    end else begin
      misaligned <= (state_q == IDLE) & mem_req & legal & access_mis;
    end
  end
`endif

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side memory access stage of the single-cycle RISC-V core. It sits directly downstream of the ALU (effective address) and register file (store data), and upstream of the write-back mux. It converts RV32I load/store requests into a single-outstanding valid/ready word bus transaction, with byte-lane steering and sign extension. While a transaction is in flight it stalls the core so PC and register writes hold.

## Interface
- ADDR_W, 32, byte-address width of `addr` and `bus_addr`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  current instruction is a load or store; held high while `stall` is high.
- `mem_we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  ADDR_W  effective byte address from the ALU.
- `store_data`  in  32  rs2 value.
- `load_data`  out  32  aligned, extended load result for write-back.
- `stall`  out  1  freezes PC and register write.
- `misaligned`  out  1  present only with `LSU_MISALIGN_TRAP_EN`.
- `bus_valid`  out  1  request valid.
- `bus_ready`  in  1  request accepted and completed; `bus_rdata` is valid in the same cycle.
- `bus_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- `bus_we`  out  1  write enable.
- `bus_wstrb`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rdata`  in  32  read word.

## Operation
- FSM states:
  - IDLE: from reset.
  - BUS: `bus_valid` high.
  - DONE: one cycle, result presented.
- Transitions:
  - IDLE & `mem_req` & legal access → BUS. The request attributes are registered on this edge.
  - IDLE & `mem_req` & unsupported `funct3` (011, 110, 111) → DONE. No bus access; `load_data` is 0.
  - BUS & `bus_ready` → DONE. `bus_rdata` is captured on this edge.
  - DONE → IDLE unconditionally. `mem_req` is ignored in DONE because it still belongs to the same instruction.
- `stall` = `mem_req` & (state != DONE). This is combinational, so the core stalls in the request cycle itself.
- Store lanes:
  - SB: `bus_wdata` = {4{byte}}, `bus_wstrb` = 0001 << addr[1:0].
  - SH: `bus_wdata` = {2{half}}, `bus_wstrb` = 0011 << {addr[1],0}.
  - SW: `bus_wstrb` = 1111.
- Loads: select the byte or half from `bus_rdata` using addr[1:0]. Sign-extend for LB/LH; zero-extend for LBU/LHU.
- `load_data` is a register. It updates only on load completion and holds its value otherwise, including across stores.
- Reset values:
  - state IDLE.
  - `bus_valid`, `bus_we`, `bus_wstrb`, `bus_addr`, `bus_wdata` all 0.
  - `load_data` 0, `misaligned` 0.
- Reset asserted mid-BUS: `bus_valid` drops immediately (asynchronously) and the transaction is abandoned.

## Timing
- Bus attributes are registered and stay stable from `bus_valid` rise until the `bus_ready` cycle. `bus_valid` never retracts before `bus_ready`.
- Zero-wait bus: request in cycle N; `bus_valid` in N+1 with `bus_ready` in N+1; DONE in N+2 with `stall` low. The core advances at the end of N+2.
- Each bus wait cycle adds one cycle of latency. No timeout.
- `bus_valid` falls in the cycle after `bus_ready`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses (H with addr[0]=1, W with addr[1:0]≠0) skip the bus and go IDLE → DONE.
  - `misaligned` pulses high for exactly the DONE cycle.
  - Stores are suppressed and `load_data` is unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - The `misaligned` port is absent.
  - Low address bits below the access size are ignored, i.e. the address is aligned down to the natural size.

## Structure
- Shared package `riscv_pkg` holds:
  - the `funct3` load/store encodings as localparams;
  - the `lsu_state_t` enum (IDLE, BUS, DONE).
- Sub-module `lsu_align`: combinational lane steering. It maps size, sign, addr[1:0] and data to wstrb, wdata and the extended load value. The FSM stays in the top module.

## Test plan
- LW at 0x100, `bus_rdata` = 0xDEADBEEF, `bus_ready` held high → `load_data` = 0xDEADBEEF; `stall` high 2 cycles then low.
- LB at 0x103, rdata = 0x80123456 → 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, data = 0x0000ABCD → `bus_addr` 0x200, `bus_wstrb` 1100, `bus_wdata` 0xABCDABCD, `bus_we` 1.
- LW with `bus_ready` low for 3 cycles → attributes stable throughout; `stall` high 5 cycles total.
- `rst` low while in BUS → `bus_valid` 0 the same cycle; FSM returns to IDLE; `load_data` 0.
- With `LSU_MISALIGN_TRAP_EN`: LW at 0x101 → no `bus_valid`; `misaligned` pulses 1 cycle; `load_data` unchanged.
